// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared widths, result entry type and helpers for the PE result path
package pe_pkg;

  localparam int TAG_W   = 4;
  localparam int NUM_ACC = 8;

  function automatic int data_w(input int int_bits, input int frac_bits);
    return int_bits + frac_bits;
  endfunction

  localparam int DATA_W = data_w(7, 9);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } pe_result_t;

endpackage

// File: rtl/pe_result_fifo.sv
// rtl/pe_result_fifo.sv - in-order synchronous FIFO of result entries with occupancy count
module pe_result_fifo
  import pe_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = $bits(pe_result_t)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/pe_result_collector.sv
// rtl/pe_result_collector.sv - aligns PE results with their tags, buffers them and streams them out
module pe_result_collector
  import pe_pkg::*;
#(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9,
  parameter int DEPTH          = 8,
  parameter int AFULL_MARGIN   = 3,
  localparam int W             = data_w(para_int_bits, para_frac_bits),
  localparam int CW            = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     pe_data,
  input  logic             pe_valid,
  input  logic [TAG_W-1:0] pe_tag,
  output logic             keep_req,
  output logic [W-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             ovf_err,
  output logic             tag_err
);

  typedef struct packed {
    logic [W-1:0]     data;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic             v_d;
  logic [TAG_W-1:0] tag_d;
  entry_t           wr_entry;
  entry_t           rd_entry;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_ok;
  logic [CW-1:0]    count_next;

  // The PE presents data one cycle after its strobe, so the tag is delayed to match.
  assign wr_entry = '{data: pe_data, tag: tag_d};

  assign out_valid  = !empty;
  assign pop        = out_valid && out_ready;
  assign push_ok    = v_d && (!full || pop);
  assign count_next = count + CW'(push_ok) - CW'(pop);

  assign out_data = rd_entry.data;
  assign out_tag  = rd_entry.tag;

  pe_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_ok),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // The margin absorbs results already launched by the PE before it sees keep_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_d      <= 1'b0;
      tag_d    <= '0;
      keep_req <= 1'b0;
      ovf_err  <= 1'b0;
      tag_err  <= 1'b0;
    end else begin
      v_d      <= pe_valid;
      tag_d    <= pe_tag;
      keep_req <= (CW'(DEPTH) - count_next) <= CW'(AFULL_MARGIN);
      if (v_d && !push_ok) ovf_err <= 1'b1;
      if (v_d && (tag_d > TAG_W'(NUM_ACC - 1))) tag_err <= 1'b1;
    end
  end

endmodule
